// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
// The state and op codes match the execute-stage control encodings.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiply / restoring shift-subtract divide loop.
// Purely combinational; built around a single WIDTH+1-bit adder with invert and carry-in.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] acc_hi_nxt,
    output logic [WIDTH-1:0] acc_lo_nxt
);

    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic             add_cin;
    logic [WIDTH+1:0] add_sum;
    logic             no_borrow;

    assign add_sum   = {1'b0, add_a} + {1'b0, add_b} + (WIDTH + 2)'(add_cin);
    assign no_borrow = add_sum[WIDTH+1];

    always_comb begin
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        acc_hi_nxt = acc_hi;
        acc_lo_nxt = acc_lo;
        if (op == OP_MUL) begin
            add_a      = {1'b0, acc_hi};
            add_b      = acc_lo[0] ? {1'b0, b} : '0;
            add_cin    = 1'b0;
            // {carry, sum, acc_lo} shifted right by one
            acc_hi_nxt = add_sum[WIDTH:1];
            acc_lo_nxt = {add_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            // Partial remainder is WIDTH+1 bits after the left shift
            add_a      = {acc_hi, acc_lo[WIDTH-1]};
            add_b      = ~{1'b0, b};
            add_cin    = 1'b1;
            acc_hi_nxt = no_borrow ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
            acc_lo_nxt = {acc_lo[WIDTH-2:0], no_borrow};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer with start/busy/done handshake.
// Stalls upstream stages while an operation is in flight.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic             dz_q;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_hi     (acc_hi),
        .acc_lo     (acc_lo),
        .b          (b_q),
        .op         (op_q),
        .acc_hi_nxt (step_hi),
        .acc_lo_nxt (step_lo)
    );

    assign busy  = (state != IDLE);
    assign stall = busy | (start & (state == IDLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            b_q         <= '0;
            op_q        <= OP_MUL;
            dz_q        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        b_q         <= B;
                        op_q        <= op;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        if (op == OP_DIV && B == '0) begin
                            acc_hi <= A;
                            acc_lo <= '1;
                            dz_q   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= A;
                            dz_q   <= 1'b0;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Results are published only on completion, so a flush here
                    // leaves the previous results visible.
                    state <= IDLE;
                    if (!flush) begin
                        done        <= 1'b1;
                        result_lo   <= acc_lo;
                        result_hi   <= acc_hi;
                        div_by_zero <= dz_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed literal cases plus random traffic
// compared every cycle against a cycle-count/arithmetic reference model.
module tb_muldiv_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic         flush;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         div_by_zero;

    always #5 clk = ~clk;

    muldiv_seq #(
        .WIDTH (W),
        .CNT_W (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .flush       (flush),
        .A           (a),
        .B           (b),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an operation occupies the unit for a fixed number of edges
    // (17 normally, 1 for divide by zero); results are plain arithmetic.
    int           m_left;
    logic         m_done;
    logic [W-1:0] m_lo, m_hi, p_lo, p_hi;
    logic         m_dbz, p_dbz;

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_lo   <= '0;
            m_hi   <= '0;
            m_dbz  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start && !flush) begin
                    m_dbz <= 1'b0;
                    if (op && b == 0) begin
                        m_left <= 1;
                        p_lo   <= 16'hFFFF;
                        p_hi   <= a;
                        p_dbz  <= 1'b1;
                    end else begin
                        m_left <= 17;
                        p_dbz  <= 1'b0;
                        if (op) begin
                            p_lo <= a / b;
                            p_hi <= a % b;
                        end else begin
                            {p_hi, p_lo} <= 32'(a) * 32'(b);
                        end
                    end
                end
            end else if (flush) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_lo   <= p_lo;
                    m_hi   <= p_hi;
                    m_dbz  <= p_dbz;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("stall", 32'(stall), 32'((m_left > 0) || start));
            chk("done", 32'(done), 32'(m_done));
            chk("result_lo", 32'(result_lo), 32'(m_lo));
            chk("result_hi", 32'(result_hi), 32'(m_hi));
            chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
        end
    end

    task automatic set_in(input logic s, input logic o, input logic f,
                          input logic [W-1:0] av, input logic [W-1:0] bv);
        start = s;
        op    = o;
        flush = f;
        a     = av;
        b     = bv;
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    // Edges counted after the accept edge until done is seen; -1 if never.
    task automatic wait_done(input int bound, output int lat);
        lat = -1;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k - 1;
                break;
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic run_op(input string nm, input logic o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int exp_lat,
                          input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                          input logic exp_dbz);
        int lat;
        set_in(1'b1, o, 1'b0, av, bv);
        next();
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk({nm, "_busy_next"}, 32'(busy), 32'(1));
        @(posedge clk);
        #2;
        wait_done(40, lat);
        if (exp_lat > 1) lat = lat + 1;
        else if (lat >= 0) lat = 1;
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_lo"}, 32'(result_lo), 32'(exp_lo));
        chk({nm, "_hi"}, 32'(result_hi), 32'(exp_hi));
        chk({nm, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        next();
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        next();
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_lo", 32'(result_lo), 32'(0));
        chk("reset_hi", 32'(result_hi), 32'(0));
        next();
        rst = 1'b0;
        next();

        run_op("mul3x5", 1'b0, 16'd3, 16'd5, 17, 16'h000F, 16'h0000, 1'b0);
        run_op("mulmax", 1'b0, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE, 1'b0);
        run_op("div100_7", 1'b1, 16'd100, 16'd7, 17, 16'd14, 16'd2, 1'b0);
        run_op("div8000_1", 1'b1, 16'h8000, 16'h0001, 17, 16'h8000, 16'h0000, 1'b0);
        run_op("divzero", 1'b1, 16'h1234, 16'h0000, 1, 16'hFFFF, 16'h1234, 1'b1);
        run_op("mul2x2", 1'b0, 16'd2, 16'd2, 17, 16'd4, 16'd0, 1'b0);

        // start while busy is ignored
        set_in(1'b1, 1'b0, 1'b0, 16'd3, 16'd5);
        next();
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (4) next();
        set_in(1'b1, 1'b0, 1'b0, 16'd9, 16'd9);
        next();
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        wait_done(30, lat);
        chk("ignored_start_seen_done", 32'(lat >= 0), 32'(1));
        chk("ignored_start_lo", 32'(result_lo), 32'd15);
        next();

        // flush mid-run: no done, results untouched
        set_in(1'b1, 1'b0, 1'b0, 16'd6, 16'd7);
        next();
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (7) next();
        flush = 1'b1;
        next();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #2;
        wait_done(25, lat);
        chk("flush_no_done", 32'(lat), 32'(-1));
        chk("flush_lo_kept", 32'(result_lo), 32'd15);

        // flush and start together in idle: nothing accepted
        set_in(1'b1, 1'b0, 1'b1, 16'd4, 16'd4);
        next();
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("flush_start_busy", 32'(busy), 32'(0));
        next();

        // reset mid-op
        set_in(1'b1, 1'b1, 1'b0, 16'd100, 16'd7);
        next();
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (5) next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_busy", 32'(busy), 32'(0));
        chk("midreset_lo", 32'(result_lo), 32'(0));
        chk("midreset_hi", 32'(result_hi), 32'(0));
        next();
        run_op("div_after_reset", 1'b1, 16'd100, 16'd7, 17, 16'd14, 16'd2, 1'b0);

        // random traffic, checked every cycle by the compare process
        for (int i = 0; i < 4000; i++) begin
            logic [W-1:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 16'($urandom_range(1, 15));
                2: ra = 16'hFFFF;
                3: ra = 16'($urandom_range(0, 255));
                default: ;
            endcase
            set_in(($urandom_range(0, 2) == 0), 1'($urandom), ($urandom_range(0, 40) == 0),
                   ra, rb);
            rst = ($urandom_range(0, 399) == 0);
            next();
        end
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (20) next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
